fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of the 8-bit synchronous byte FIFO between NUM_REQ requesters. Each requester uses a valid/ready/last byte stream.
- A grant covers one burst. The burst ends on the last byte, after MAX_BURST bytes, or after HOLD_TIMEOUT idle cycles.
- The block sits between the producers (UART RX, DMA, CPU mailbox) and the FIFO's wr_en/data_in/fifo_full.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that lets NUM_REQ valid/ready/last byte streams share
//   the single write port of an 8-bit synchronous FIFO. One grant covers one
//   burst. A burst ends on an accepted last byte, after MAX_BURST accepted
//   bytes, or after HOLD_TIMEOUT consecutive cycles with the grantee's valid low.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req_valid[N]      per-requester byte valid
//   req_data[N*8]     per-requester byte, requester i on [8i+7:8i]
//   req_last[N]       final byte of a burst (looked at only on an accepted beat)
//   req_ready[N]      per-requester ready, at most one bit high
//   fifo_full         FIFO full flag
//   fifo_wr_en        FIFO write strobe (never high while fifo_full)
//   fifo_data_in      byte to the FIFO, zero when fifo_wr_en is low
//   grant_id          current or most recent grantee
//   busy              high while a grant is active
//   beat_count        total accepted bytes, saturating at 16'hFFFF
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDW          = 2,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [7:0]           fifo_data_in,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [15:0]          beat_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                   state;
    logic [IDW-1:0]           last_grant;
    logic [7:0]               burst_cnt;
    logic [7:0]               hold_cnt;

    logic [NUM_REQ-1:0]       sel;
    logic [NUM_REQ-1:0]       lane_beat;
    logic [NUM_REQ-1:0][7:0]  lane_data;
    logic                     cur_valid;
    logic                     cur_last;
    logic                     release_grant;

    logic                     arb_found;
    logic [IDW-1:0]           arb_idx;
    logic [IW-1:0]            idx;

    // Per-lane ready / beat / gated data. A lane is selected only in XFER,
    // so everything here is forced low in IDLE.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign sel[g]       = (state == XFER) && (grant_id == IDW'(g));
        assign req_ready[g] = sel[g] & ~fifo_full;
        assign lane_beat[g] = req_ready[g] & req_valid[g];
        assign lane_data[g] = lane_beat[g] ? req_data[8*g +: 8] : 8'h00;
    end

    assign fifo_wr_en = |lane_beat;
    assign cur_valid  = |(req_valid & sel);
    assign cur_last   = |(req_last & sel);
    assign busy       = (state == XFER);

    // Lanes are gated to zero unless beating, so an OR collapses them.
    always_comb begin
        fifo_data_in = 8'h00;
        for (int i = 0; i < NUM_REQ; i++)
            fifo_data_in = fifo_data_in | lane_data[i];
    end

    // Round-robin pick: first valid index scanning upward from last_grant+1.
    // The previous grantee is checked last, which gives it lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!arb_found && req_valid[idx]) begin
                arb_found = 1'b1;
                arb_idx   = IDW'(idx);
            end
        end
    end

    // A stalled-by-full beat (valid high, no write) never counts toward the
    // hold timeout, so a full FIFO alone cannot release the grant.
    assign release_grant = (state == XFER) &&
        ((fifo_wr_en && (cur_last || burst_cnt == 8'(MAX_BURST - 1))) ||
         (!fifo_wr_en && !cur_valid && hold_cnt == 8'(HOLD_TIMEOUT - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDW'(NUM_REQ - 1);
            grant_id   <= '0;
            burst_cnt  <= 8'h00;
            hold_cnt   <= 8'h00;
            beat_count <= 16'h0000;
        end else begin
            if (fifo_wr_en && beat_count != 16'hFFFF)
                beat_count <= beat_count + 16'd1;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_id  <= arb_idx;
                        burst_cnt <= 8'h00;
                        hold_cnt  <= 8'h00;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (fifo_wr_en) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        hold_cnt  <= 8'h00;
                    end else if (!cur_valid) begin
                        hold_cnt  <= hold_cnt + 8'd1;
                    end
                    if (release_grant) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
